display_scan_ctrl: RTL
======================

Name: display_scan_ctrl

Overview:
- Time-multiplexes one combinational hex-to-7-segment decoder across DIGITS common-anode digits.
- Holds a double-buffered display value and presents one nibble per slot to the decoder. It gates the returned segment pattern and drives active-low digit anodes.
- Includes an anti-ghosting guard gap between digits and optional leading-zero blanking.
- Sits between the value producer (valid/ready handshake) and the board's segment and anode pins.

Parameters:
- DIGITS, 4: number of multiplexed digits; digit 0 is least significant. Legal range 2..8.
- PRESCALE, 50000: clk cycles each digit is lit. Minimum 1.
- GUARD, 2: clk cycles with all anodes off between digits. Minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- value_in  in  4*DIGITS  value to display; nibble i is bits [4i+3:4i].
- load_valid  in  1  value_in valid.
- load_ready  out  1  pending buffer free.
- scan_en  in  1  1 = scan the display, 0 = display dark.
- lz_blank  in  1  leading-zero blanking enable.
- dec_num  out  4  nibble to the decoder input; bit 3 is the MSB of the nibble.
- dec_seg  in  7  decoder segment pattern, active-low.
- seg  out  7  segment pins, active-low; 7'h7F = all off.
- an  out  DIGITS  anode enables, active-low, at most one bit low.
- digit_idx  out  clog2(DIGITS)  index of the current digit.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Registers: active (4*DIGITS), pending (4*DIGITS), pend_full, state, pre_cnt, digit_idx.
- Reset (async): active=0, pending=0, pend_full=0, state=IDLE, pre_cnt=0, digit_idx=0.
- Output values while in reset: an all ones, seg=7'h7F, dec_num=0, load_ready=1, frame_done=0.
- Handshake: load_ready = ~pend_full.
  - On a clk edge with load_valid & load_ready: pending<=value_in, pend_full<=1.
  - value_in is ignored when load_ready=0; the producer holds valid.
- Transfer (pending to active, pend_full<=0):
  - In IDLE: on the first edge with pend_full=1.
  - In SCAN/GUARD: only on the frame-boundary edge, and only if pend_full was already 1 before that edge.
  - A load accepted on the boundary edge itself transfers at the next boundary.
- IDLE:
  - an all ones, seg=7'h7F, pre_cnt=0, digit_idx=0.
  - scan_en=1 -> SCAN on the next edge, with pre_cnt=0 and digit_idx=0.
- SCAN:
  - an[digit_idx]=0, all other an bits =1. dec_num=active nibble[digit_idx].
  - seg=dec_seg, or 7'h7F if the digit is blanked.
  - pre_cnt increments each cycle. At pre_cnt==PRESCALE-1: go to GUARD, pre_cnt<=0.
- GUARD:
  - an all ones, seg=7'h7F.
  - pre_cnt counts to GUARD-1, then: go to SCAN, pre_cnt<=0, digit_idx<=digit_idx+1.
  - At digit_idx==DIGITS-1, digit_idx wraps to 0 instead. That edge is the frame boundary: frame_done=1 for that cycle only.
- Timing:
  - Each digit is lit for exactly PRESCALE cycles.
  - Frame period = DIGITS*(PRESCALE+GUARD) cycles.
  - dec_num, seg and an are combinational from registered state; zero added latency.
- Leading-zero blanking: digit i (i>0) is blanked when lz_blank=1 and active nibbles DIGITS-1 down to i are all 0. Digit 0 is never blanked. A blanked digit keeps its anode timing and shows seg=7'h7F.
- scan_en=0 in SCAN or GUARD: IDLE on the next edge. Counters clear; active and pending are retained. Re-enable starts at digit 0 with a full PRESCALE slot.
- Reset mid-operation: all registers clear immediately, with no clock edge; any pending value is lost.

Test Plan (DIGITS=4, PRESCALE=4, GUARD=2, real decoder on dec_num/dec_seg):
- Scan order: reset, load 0x1234 in IDLE, then scan_en=1.
  - an=1110 with seg=7'b0011001 for 4 cycles, then an=1111 seg=7F for 2 cycles.
  - Then an=1101 seg=7'b0110000, an=1011 seg=7'b0100100, an=0111 seg=7'b1111001.
  - frame_done pulses once every 24 cycles.
- Leading zeros: value 0x0050 with lz_blank=1.
  - Digits 3 and 2 show seg=7F with their anodes low.
  - Digit 1 shows 7'b0010010; digit 0 shows 7'b1000000.
  - Value 0x0000 shows only digit 0 = 7'b1000000.
- Double buffer: mid-frame load 0xABCD.
  - load_ready=0 next cycle; display keeps 0x1234 until the frame_done edge, then shows 0xABCD from digit 0.
  - A second load held valid is accepted the cycle after the transfer.
- Boundary load: load_valid on the exact boundary edge with pend_full=0.
  - Value is captured, not shown this frame, shown after the next frame_done.
- scan_en drop: scan_en=0 during digit 2's lit slot.
  - Next cycle an=1111, seg=7F, digit_idx=0.
  - Re-enable gives an=1110 for a full 4 cycles.
- Async reset: assert rst between clock edges during GUARD.
  - All outputs take reset values immediately; load_ready=1; the pending value is discarded.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered value, guard gap
// between digits, optional leading-zero blanking, shared external decoder.
module display_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*DIGITS-1:0]       value_in,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic                      scan_en,
  input  logic                      lz_blank,
  output logic [3:0]                dec_num,
  input  logic [6:0]                dec_seg,
  output logic [6:0]                seg,
  output logic [DIGITS-1:0]         an,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic                      frame_done
);
  localparam int IW   = $clog2(DIGITS);
  localparam int CMAX = (PRESCALE > GUARD) ? PRESCALE : GUARD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_GUARD} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] active;
  logic [4*DIGITS-1:0] pending;
  logic                pend_full;
  logic [CW-1:0]       pre_cnt;
  logic [DIGITS-1:0]   blank;
  logic                zero_run;
  logic                scan_last;
  logic                guard_last;
  logic                digit_last;
  logic                boundary;

  assign scan_last  = (pre_cnt == CW'(PRESCALE - 1));
  assign guard_last = (pre_cnt == CW'(GUARD - 1));
  assign digit_last = (digit_idx == IW'(DIGITS - 1));
  // Last guard cycle of the last digit; the following edge wraps to digit 0.
  assign boundary   = (state == S_GUARD) && guard_last && digit_last && scan_en;
  assign frame_done = boundary;
  assign load_ready = ~pend_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      pre_cnt   <= '0;
      digit_idx <= '0;
    end else begin
      // A load taken on the boundary edge sees pend_full=0, so it waits a frame.
      if (pend_full && (state == S_IDLE || boundary)) begin
        active    <= pending;
        pend_full <= 1'b0;
      end else if (load_valid && !pend_full) begin
        pending   <= value_in;
        pend_full <= 1'b1;
      end

      if (!scan_en) begin
        state     <= S_IDLE;
        pre_cnt   <= '0;
        digit_idx <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_SCAN;
            pre_cnt   <= '0;
            digit_idx <= '0;
          end
          S_SCAN: begin
            if (scan_last) begin
              state   <= S_GUARD;
              pre_cnt <= '0;
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
          S_GUARD: begin
            if (guard_last) begin
              state     <= S_SCAN;
              pre_cnt   <= '0;
              digit_idx <= digit_last ? '0 : digit_idx + 1'b1;
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Digit i is blanked when it and every more-significant nibble are zero.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (active[4*i +: 4] == 4'h0);
      blank[i] = lz_blank && zero_run;
    end
  end

  always_comb begin
    an      = '1;
    seg     = 7'h7F;
    dec_num = 4'h0;
    if (state == S_SCAN) begin
      an[digit_idx] = 1'b0;
      dec_num       = active[4*digit_idx +: 4];
      seg           = blank[digit_idx] ? 7'h7F : dec_seg;
    end
  end
endmodule
